mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline. It sits in EX beside the ALU and receives operands from the forwarding muxes. Its sign mode comes from the same decoder field family as the immediate extender's control. It sequences each mult/div operation over a fixed number of cycles and drives `busy` to the hazard unit, which stalls D-stage MD instructions while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy duration for div/divu (≥1)

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  EX-stage MD instruction valid this cycle
- `MDOp`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 no-op
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `busy`  out  1  operation in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- The clock is `clk`. `reset` is asynchronous and active-high.
- Reset clears `HI` = 0, `LO` = 0, `busy` = 0, the state to IDLE, the counter to 0 and the pending result to 0.
- States:
  - IDLE → RUN on `start` with MDOp 0–3.
  - RUN → IDLE when the counter reaches 1 at a clock edge.
- On entering RUN:
  - counter ← `MULT_CYCLES` for MDOp 0–1, or `DIV_CYCLES` for MDOp 2–3.
  - pending {HI,LO} ← computed from A/B sampled at the start edge.
  - Operands are not re-read during RUN.
- Arithmetic:
  - mult: 64-bit signed product; HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (B = 0):
  - The unit still runs `DIV_CYCLES`.
  - At completion HI/LO keep their previous values.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- Completion: HI/LO take the pending values on the edge that leaves RUN.
- mthi/mtlo (MDOp 4/5) with `start` in IDLE write A into HI/LO on the next edge. They never assert `busy`.
- `start` while in RUN is ignored. The hazard unit guarantees it never happens; verification flags it as an assertion.
- MDOp 6–7 with `start` is ignored.

## Timing
- `busy` is registered.
- For a start at edge E0, `busy` is high after E0 through edge E0+N, where N is the operation's cycle parameter. It falls after E0+N, and HI/LO hold the new values after that same edge.
- Hazard unit stall term is `start | busy`, covering the issue cycle.
- mfhi/mflo issued after `busy` falls read the new values. There is no bypass of pending results.
- A new op may start on the cycle immediately after `busy` falls (back-to-back).
- mthi/mtlo latency: 1 edge.
- Reset mid-RUN:
  - Aborts immediately: `busy` = 0 and the state is IDLE.
  - HI/LO = 0; the pending result is discarded.
- When `reset` deasserts, the first edge with `start` is accepted normally.

## Structure
- Shared package/header holds:
  - MDOp encodings, `MD_MULT`…`MD_MTLO`
  - state encodings `MD_IDLE`, `MD_RUN`
  - default cycle counts
- Counter width is `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`.
- One natural sub-module: `md_arith`, combinational, computing the 64-bit {HI,LO} for MDOp 0–3 plus a `div0` flag. The top level holds the FSM, counter, pending register and HI/LO.

## Test plan
- Reset, then mult A=0xFFFFFFFF, B=2 → busy high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu same operands → LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → busy stays 0; HI/LO update one edge each.
- div B=0 after HI=0xAA, LO=0xBB → busy 10 cycles, HI/LO unchanged. Then div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Back-to-back mult 3×4 then divu 100/7 started the cycle `busy` falls → HI=0, LO=12 after the first; then LO=14, HI=2 after 10 more cycles.
- Assert `reset` in cycle 3 of a div → busy, HI and LO are 0 asynchronously. No late HI/LO write occurs after release.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Imported by md_arith and mult_div_unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic int md_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu.
// div0 flags a divide op with a zero divisor.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic               is_div;
  logic               is_divu;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvd;
  logic [31:0]        dvs;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        sq;
  logic [31:0]        sr;

  always_comb begin
    is_div  = (op == MD_DIV);
    is_divu = (op == MD_DIVU);
    div0    = (is_div || is_divu) && (b == 32'd0);

    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    dvd = (is_div && a[31]) ? (~a + 32'd1) : a;
    dvs = (is_div && b[31]) ? (~b + 32'd1) : b;
    uq  = (b == 32'd0) ? 32'd0 : dvd / dvs;
    ur  = (b == 32'd0) ? 32'd0 : dvd % dvs;
    sq  = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    sr  = a[31] ? (~ur + 32'd1) : ur;

    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {sr, sq};
      MD_DIVU:  result = {ur, uq};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at issue and committed to HI/LO when the busy window ends.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [63:0] pend_reg, pend_next;
  logic        pend_div0_reg, pend_div0_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        busy_reg, busy_next;

  logic [63:0] arith_result;
  logic        arith_div0;
  logic        is_mul_op;
  logic        is_div_op;

  md_arith u_arith (
    .op     (MDOp),
    .a      (A),
    .b      (B),
    .result (arith_result),
    .div0   (arith_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= MD_IDLE;
      cnt_reg       <= '0;
      pend_reg      <= 64'd0;
      pend_div0_reg <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pend_reg      <= pend_next;
      pend_div0_reg <= pend_div0_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pend_next      = pend_reg;
    pend_div0_next = pend_div0_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    busy_next      = busy_reg;

    is_mul_op = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    is_div_op = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);

    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          if (is_mul_op || is_div_op) begin
            state_next     = MD_RUN;
            cnt_next       = is_mul_op ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_next      = arith_result;
            pend_div0_next = arith_div0;
            busy_next      = 1'b1;
          end else if (MDOp == MD_MTHI) begin
            hi_next = A;
          end else if (MDOp == MD_MTLO) begin
            lo_next = A;
          end
        end
      end
      MD_RUN: begin
        // start is ignored here; the hazard unit never issues into a busy unit.
        if (cnt_reg == CW'(1)) begin
          state_next = MD_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          if (!pend_div0_reg) begin
            hi_next = pend_reg[63:32];
            lo_next = pend_reg[31:0];
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = MD_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand sequences
// for back-to-back and reset-abort, then random ops against an arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin sp = sa * sb; hi_m = sp[63:32]; lo_m = sp[31:0]; end
      3'd1: begin up = ua * ub; hi_m = up[63:32]; lo_m = up[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo_m = sq[31:0]; hi_m = sr[31:0]; end
      3'd3: if (b != 0) begin uq = ua / ub; ur = ua % ub; lo_m = uq[31:0]; hi_m = ur[31:0]; end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endfunction

  function automatic int model_cycles(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Called just after a negedge; returns the number of cycles busy was seen high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    MDOp  = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    $display("op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, a, b, n, HI, LO);
  endtask

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4] = '{3'd4, 32'h000000AA, 32'd0,          32'h000000AA, 32'h7FFFFFFC, 0};
    vecs[5] = '{3'd5, 32'h000000BB, 32'd0,          32'h000000AA, 32'h000000BB, 0};
    vecs[6] = '{3'd2, 32'h00000005, 32'd0,          32'h000000AA, 32'h000000BB, 10};
    vecs[7] = '{3'd2, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, 10};

    reset = 1'b1;
    start = 1'b0;
    MDOp  = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    hi_m  = 32'd0;
    lo_m  = 32'd0;
    repeat (2) @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      model(vecs[i].op, vecs[i].a, vecs[i].b);
      check32($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check32($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
      check32($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
    end

    // mthi then mtlo on consecutive cycles: one-edge latency, never busy.
    MDOp = 3'd4; A = 32'h12345678; start = 1'b1;
    @(negedge clk);
    check32("mthi_busy", {31'd0, busy}, 32'd0);
    check32("mthi_hi", HI, 32'h12345678);
    MDOp = 3'd5; A = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check32("mtlo_busy", {31'd0, busy}, 32'd0);
    check32("mtlo_lo", LO, 32'h9ABCDEF0);
    check32("mtlo_hi_kept", HI, 32'h12345678);
    $display("op=4/5 back-to-back hi=%h lo=%h", HI, LO);
    hi_m = 32'h12345678;
    lo_m = 32'h9ABCDEF0;

    // Back-to-back: divu issued the cycle busy falls after a mult.
    run_op(3'd0, 32'd3, 32'd4, n);
    check32("b2b_mult_cycles", 32'(n), 32'd5);
    check32("b2b_mult_hi", HI, 32'd0);
    check32("b2b_mult_lo", LO, 32'd12);
    MDOp = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check32("b2b_divu_busy", {31'd0, busy}, 32'd1);
    check32("b2b_no_bypass_lo", LO, 32'd12);
    n = 1;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    check32("b2b_divu_cycles", 32'(n), 32'd10);
    check32("b2b_divu_hi", HI, 32'd2);
    check32("b2b_divu_lo", LO, 32'd14);
    $display("op=3 a=%h b=%h busy_cycles=%0d hi=%h lo=%h", 32'd100, 32'd7, n, HI, LO);

    // Reset in cycle 3 of a div clears everything asynchronously.
    MDOp = 3'd2; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check32("rst_mid_busy", {31'd0, busy}, 32'd0);
    check32("rst_mid_hi", HI, 32'd0);
    check32("rst_mid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check32("rst_after_busy", {31'd0, busy}, 32'd0);
    check32("rst_after_hi", HI, 32'd0);
    check32("rst_after_lo", LO, 32'd0);
    $display("reset abort during div hi=%h lo=%h busy=%0d", HI, LO, busy);
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Randomized ops against the model, including 6-7 no-ops and zero divisors.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op(rop, ra, rb, n);
      model(rop, ra, rb);
      check32($sformatf("rnd%0d_cycles", i), 32'(n), 32'(model_cycles(rop)));
      check32($sformatf("rnd%0d_hi", i), HI, hi_m);
      check32($sformatf("rnd%0d_lo", i), LO, lo_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
